robo_navegador: RTL
===================

// Module: robo_navegador
// PURPOSE
//  Autonomous maze controller for the robot: the command-issuing end of the memo interface.
//  Reads the memo sensor outputs (head, left, under, barrier) and runs a left-hand wall-follower.
//  Issues one movement command at a time over a valid/ready handshake, then waits for refreshed sensors.
//  Sits in Top between the gamepad/manual-step logic and memo, and replaces gamepad driving in auto mode.
// PARAMETERS
//  MOVE_W     10    width of move_cnt
//  MAX_MOVES  1000  AVANCAR limit; a further AVANCAR decision -> ERROR (must fit MOVE_W)
//  STEP_MODE  0     1: every DECIDE waits for a step pulse (manual_clock single-step)
// PORTS
//  clock      in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  start      in   1       1-cycle pulse, begins navigation from IDLE
//  step       in   1       single-step strobe; used only when STEP_MODE=1
//  head       in   1       1 = wall directly ahead
//  left       in   1       1 = wall on robot's left
//  under      in   1       1 = robot is on the exit cell
//  barrier    in   1       1 = removable barrier ahead
//  sens_valid in   1       memo pulse: sensors are updated after the last command
//  cmd_ready  in   1       memo accepts cmd this cycle
//  cmd_valid  out  1       command offered
//  cmd        out  3       0 NOP, 1 AVANCAR, 2 GIRA_ESQ, 3 GIRA_DIR, 4 REMOVE
//  busy       out  1       state not IDLE/DONE/ERROR
//  done       out  1       exit reached (sticky)
//  error      out  1       trapped or move limit hit (sticky)
//  move_cnt   out  MOVE_W  accepted AVANCAR count
// BEHAVIOUR
//  Reset (sync): state IDLE; cmd_valid=0, cmd=0, busy=0, done=0, error=0, move_cnt=0, turn_cnt=0, turned_left=0.
//  States: IDLE, DECIDE, ISSUE, WAIT_SENS, DONE, ERROR.
//  IDLE: start=1 -> capture head/left/under/barrier into sensor regs -> DECIDE. Otherwise hold.
//  DECIDE: one cycle (if STEP_MODE=1, hold until step=1). First matching rule on the sensor regs:
//   1 under=1 -> DONE.
//   2 left=0 and turned_left=0 -> GIRA_ESQ, then set turned_left.
//   3 barrier=1 -> REMOVE.
//   4 head=0 -> AVANCAR, then clear turned_left (ERROR instead if move_cnt==MAX_MOVES).
//   5 else -> GIRA_DIR.
//   Any turn with turn_cnt==4 -> ERROR instead of the turn.
//   Command decisions go to ISSUE with cmd registered and cmd_valid=1 on the same edge.
//  Latency: start at edge k -> cmd_valid=1 after edge k+1 (STEP_MODE=0).
//  ISSUE: cmd and cmd_valid stay stable until cmd_valid&&cmd_ready at a rising edge.
//   On that edge: cmd_valid=0, cmd=0, state -> WAIT_SENS.
//   AVANCAR: move_cnt+1 and turn_cnt=0. GIRA_*: turn_cnt+1. REMOVE: counters unchanged.
//  cmd_ready while cmd_valid=0 is ignored.
//  WAIT_SENS: sens_valid=1 -> capture sensors -> DECIDE. A sens_valid pulse in the transfer cycle itself is ignored.
//  DONE/ERROR: sticky flag =1, busy=0, cmd_valid=0; start and step ignored; left only by reset.
//  busy=1 in DECIDE, ISSUE and WAIT_SENS.
//  move_cnt never wraps (bounded by MAX_MOVES). turn_cnt is 3 bits.
//  Reset asserted mid-handshake: cmd_valid=0 after that edge, with no transfer counted.
//  start while busy is ignored.
// TESTING
//  Sensors l=0,h=0,u=0,b=0, start -> GIRA_ESQ; sens same -> AVANCAR (turned_left blocks 2nd left); move_cnt=1.
//  l=1,h=1,b=0 repeated -> GIRA_DIR x4, then ERROR=1, cmd_valid=0, move_cnt unchanged.
//  l=1,b=1 -> REMOVE; with b=0,h=0 -> AVANCAR; cmd_ready held low 5 cycles -> cmd=1 stable, one transfer.
//  u=1 on first sample -> done=1 two edges after start, no cmd_valid ever.
//  MAX_MOVES=3, l=1,h=0 always -> 3 AVANCAR accepted, then error=1, move_cnt=3.
//  STEP_MODE=1: no cmd_valid until step pulse. Reset during ISSUE -> all outputs 0 next edge.

Source files
------------

// File: rtl/robo_navegador.sv
// Left-hand wall-following maze controller: samples memo sensors, decides one move,
// offers it over a valid/ready handshake, then waits for refreshed sensors.
module robo_navegador #(
   parameter int MOVE_W    = 10,
   parameter int MAX_MOVES = 1000,
   parameter int STEP_MODE = 0
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              step,
   input  logic              head,
   input  logic              left,
   input  logic              under,
   input  logic              barrier,
   input  logic              sens_valid,
   input  logic              cmd_ready,
   output logic              cmd_valid,
   output logic [2:0]        cmd,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [MOVE_W-1:0] move_cnt
);

   typedef enum logic [2:0] {
      S_IDLE, S_DECIDE, S_ISSUE, S_WAIT_SENS, S_DONE, S_ERROR
   } state_t;

   localparam logic [2:0] CMD_NOP      = 3'd0;
   localparam logic [2:0] CMD_AVANCAR  = 3'd1;
   localparam logic [2:0] CMD_GIRA_ESQ = 3'd2;
   localparam logic [2:0] CMD_GIRA_DIR = 3'd3;
   localparam logic [2:0] CMD_REMOVE   = 3'd4;
   localparam logic [MOVE_W-1:0] MOVE_LIMIT = MOVE_W'(MAX_MOVES);

   state_t      state, state_nxt;
   logic [2:0]  dec_cmd;
   logic [2:0]  cmd_q;
   logic [2:0]  turn_cnt;
   logic        turned_left;
   logic        s_head, s_left, s_under, s_barrier;
   logic        step_ok;
   logic        xfer;

   assign step_ok = (STEP_MODE == 0) || step;
   assign xfer    = cmd_valid && cmd_ready;
   assign cmd     = cmd_q;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      dec_cmd   = CMD_NOP;
      case (state)
         S_IDLE:      if (start) state_nxt = S_DECIDE;
         S_DECIDE: begin
            if (step_ok) begin
               if (s_under) begin
                  state_nxt = S_DONE;
               end else begin
                  if (!s_left && !turned_left) dec_cmd = CMD_GIRA_ESQ;
                  else if (s_barrier)          dec_cmd = CMD_REMOVE;
                  else if (!s_head)            dec_cmd = CMD_AVANCAR;
                  else                         dec_cmd = CMD_GIRA_DIR;
                  state_nxt = S_ISSUE;
                  // Trapped (spun a full circle) or out of moves: stop instead of issuing
                  if (((dec_cmd == CMD_GIRA_ESQ) || (dec_cmd == CMD_GIRA_DIR)) && (turn_cnt == 3'd4))
                     state_nxt = S_ERROR;
                  if ((dec_cmd == CMD_AVANCAR) && (move_cnt == MOVE_LIMIT))
                     state_nxt = S_ERROR;
               end
            end
         end
         S_ISSUE:     if (xfer) state_nxt = S_WAIT_SENS;
         S_WAIT_SENS: if (sens_valid) state_nxt = S_DECIDE;
         S_DONE:      state_nxt = S_DONE;
         S_ERROR:     state_nxt = S_ERROR;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      cmd_valid = (state == S_ISSUE);
      busy      = (state == S_DECIDE) || (state == S_ISSUE) || (state == S_WAIT_SENS);
      done      = (state == S_DONE);
      error     = (state == S_ERROR);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q       <= CMD_NOP;
         move_cnt    <= '0;
         turn_cnt    <= 3'd0;
         turned_left <= 1'b0;
         s_head      <= 1'b0;
         s_left      <= 1'b0;
         s_under     <= 1'b0;
         s_barrier   <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_WAIT_SENS: begin
               if ((state == S_IDLE && start) || (state == S_WAIT_SENS && sens_valid)) begin
                  s_head    <= head;
                  s_left    <= left;
                  s_under   <= under;
                  s_barrier <= barrier;
               end
            end
            S_DECIDE: begin
               if (state_nxt == S_ISSUE) begin
                  cmd_q <= dec_cmd;
                  if (dec_cmd == CMD_GIRA_ESQ) turned_left <= 1'b1;
                  if (dec_cmd == CMD_AVANCAR)  turned_left <= 1'b0;
               end
            end
            S_ISSUE: begin
               if (xfer) begin
                  cmd_q <= CMD_NOP;
                  if (cmd_q == CMD_AVANCAR) begin
                     move_cnt <= move_cnt + MOVE_W'(1);
                     turn_cnt <= 3'd0;
                  end else if ((cmd_q == CMD_GIRA_ESQ) || (cmd_q == CMD_GIRA_DIR)) begin
                     turn_cnt <= turn_cnt + 3'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule
